// File: rtl/spi_slave.sv
// SPI slave front end: frames 10-bit command/payload words from MOSI and
// streams a memory read word back out on MISO after a read-data command.
module spi_slave #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    localparam logic [3:0] CNT_LAST = 4'(WORD_W - 2);
    localparam int         TXC_W    = $clog2(DATA_W + 1);

    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [WORD_W-2:0] rx_shift;
    logic [WORD_W-1:0] rx_next;
    logic              frame_done;
    logic              rd_addr_flag;
    logic [DATA_W-1:0] tx_shift;
    logic [TXC_W-1:0]  tx_cnt;
    logic              tx_busy;
    logic              tx_done;

    assign rx_next = {rx_shift, MOSI};

    // Frame bits keep shifting until bit 0 lands; SS_n high wins over everything
    // except completing a frame on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            rd_addr_flag <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!SS_n) state <= CHK_CMD;
                end
                CHK_CMD: begin
                    if (SS_n) begin
                        state <= IDLE;
                    end else begin
                        rx_shift   <= rx_next[WORD_W-2:0];
                        bit_cnt    <= '0;
                        frame_done <= 1'b0;
                        if (!MOSI)             state <= WRITE;
                        else if (rd_addr_flag) state <= READ_DATA;
                        else                   state <= READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!frame_done) begin
                        if (bit_cnt == CNT_LAST) begin
                            rx_data    <= rx_next;
                            rx_valid   <= 1'b1;
                            frame_done <= 1'b1;
                            if (state == READ_ADD) rd_addr_flag <= 1'b1;
                        end else begin
                            rx_shift <= rx_next[WORD_W-2:0];
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end else if (state == READ_DATA && !SS_n) begin
                        // One capture per frame; the word then drains MSB first.
                        if (tx_busy) begin
                            if (tx_cnt != '0) begin
                                MISO     <= tx_shift[DATA_W-1];
                                tx_shift <= tx_shift << 1;
                                tx_cnt   <= tx_cnt - 1'b1;
                            end else begin
                                MISO         <= 1'b0;
                                tx_busy      <= 1'b0;
                                tx_done      <= 1'b1;
                                rd_addr_flag <= 1'b0;
                            end
                        end else if (!tx_done && tx_valid) begin
                            MISO     <= tx_data[DATA_W-1];
                            tx_shift <= tx_data << 1;
                            tx_cnt   <= TXC_W'(DATA_W - 1);
                            tx_busy  <= 1'b1;
                        end
                    end
                    if (SS_n) begin
                        state      <= IDLE;
                        frame_done <= 1'b0;
                        bit_cnt    <= '0;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b0;
                        MISO       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frame decode, read streaming, aborts and reset.
module tb_spi_slave;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_READ_ADD  = 3'd3;
    localparam logic [2:0] S_READ_DATA = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    spi_slave #(.WORD_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_valid === 1'b1) pulse_cnt++;

    // Returns at the negedge where bit 0 is driven; the next posedge samples it.
    task automatic drive_frame(input logic [9:0] w);
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk); MOSI = w[9];
        for (int i = 8; i >= 0; i--) begin
            @(negedge clk); MOSI = w[i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL reset_miso: got %b want 0", MISO); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 10'h000) begin bad++; $display("[TB] FAIL reset_rx_data: got %h want 000", rx_data); end
        total++; if (dut.state !== S_IDLE) begin bad++; $display("[TB] FAIL reset_state: got %0d want %0d", dut.state, S_IDLE); end
        total++; if (dut.rd_addr_flag !== 1'b0) begin bad++; $display("[TB] FAIL reset_flag: got %b want 0", dut.rd_addr_flag); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_addr();
        pulse_cnt = 0;
        drive_frame(10'h055);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL wa_early_valid: got %b want 0", rx_valid); end
        @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL wa_valid: got %b want 1", rx_valid); end
        total++; if (rx_data !== 10'h055) begin bad++; $display("[TB] FAIL wa_data: got %h want 055", rx_data); end
        total++; if (dut.state !== S_WRITE) begin bad++; $display("[TB] FAIL wa_state: got %0d want %0d", dut.state, S_WRITE); end
        total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL wa_miso: got %b want 0", MISO); end
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL wa_pulse_width: got %b want 0", rx_valid); end
        end_frame();
        total++; if (pulse_cnt !== 1) begin bad++; $display("[TB] FAIL wa_pulse_count: got %0d want 1", pulse_cnt); end
    endtask

    task automatic test_write_data();
        pulse_cnt = 0;
        drive_frame(10'h1AA);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); MOSI = i[0];
        end
        total++; if (rx_data !== 10'h1AA) begin bad++; $display("[TB] FAIL wd_data: got %h want 1AA", rx_data); end
        total++; if (dut.state !== S_WRITE) begin bad++; $display("[TB] FAIL wd_state_hold: got %0d want %0d", dut.state, S_WRITE); end
        end_frame();
        total++; if (pulse_cnt !== 1) begin bad++; $display("[TB] FAIL wd_pulse_count: got %0d want 1", pulse_cnt); end
        total++; if (rx_data !== 10'h1AA) begin bad++; $display("[TB] FAIL wd_data_hold: got %h want 1AA", rx_data); end
    endtask

    task automatic test_read_sequence();
        logic [7:0] exp_byte;
        exp_byte = 8'hC5;
        drive_frame(10'h203);
        @(negedge clk);
        total++; if (rx_data !== 10'h203) begin bad++; $display("[TB] FAIL rd_addr_data: got %h want 203", rx_data); end
        total++; if (dut.rd_addr_flag !== 1'b1) begin bad++; $display("[TB] FAIL rd_addr_flag: got %b want 1", dut.rd_addr_flag); end
        end_frame();
        drive_frame(10'h3A5);
        @(negedge clk);
        total++; if (rx_data !== 10'h3A5) begin bad++; $display("[TB] FAIL rd_data_frame: got %h want 3A5", rx_data); end
        total++; if (dut.state !== S_READ_DATA) begin bad++; $display("[TB] FAIL rd_data_state: got %0d want %0d", dut.state, S_READ_DATA); end
        @(negedge clk);
        @(negedge clk);
        total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle_miso: got %b want 0", MISO); end
        tx_data = exp_byte; tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            tx_valid = 1'b0; tx_data = 8'h00;
            total++; if (MISO !== exp_byte[i]) begin bad++; $display("[TB] FAIL rd_miso_bit%0d: got %b want %b", i, MISO, exp_byte[i]); end
        end
        @(negedge clk);
        total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL rd_miso_after: got %b want 0", MISO); end
        total++; if (dut.rd_addr_flag !== 1'b0) begin bad++; $display("[TB] FAIL rd_flag_clear: got %b want 0", dut.rd_addr_flag); end
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL rd_late_tx_valid: got %b want 0", MISO); end
        end_frame();
    endtask

    task automatic test_abort();
        pulse_cnt = 0;
        @(negedge clk); SS_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); MOSI = 1'b1;
        end
        SS_n = 1'b1;
        @(negedge clk);
        total++; if (dut.state !== S_IDLE) begin bad++; $display("[TB] FAIL abort_state: got %0d want %0d", dut.state, S_IDLE); end
        repeat (12) @(negedge clk);
        total++; if (pulse_cnt !== 0) begin bad++; $display("[TB] FAIL abort_pulses: got %0d want 0", pulse_cnt); end
        drive_frame(10'h0F0);
        @(negedge clk);
        total++; if (rx_data !== 10'h0F0 || rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL abort_recover: got %h/%b want 0F0/1", rx_data, rx_valid); end
        end_frame();
    endtask

    task automatic test_ss_rise_on_last_bit();
        pulse_cnt = 0;
        drive_frame(10'h0C3);
        SS_n = 1'b1;
        @(negedge clk);
        total++; if (rx_valid !== 1'b1 || rx_data !== 10'h0C3) begin bad++; $display("[TB] FAIL last_bit_frame: got %b/%h want 1/0C3", rx_valid, rx_data); end
        total++; if (dut.state !== S_IDLE) begin bad++; $display("[TB] FAIL last_bit_state: got %0d want %0d", dut.state, S_IDLE); end
        repeat (3) @(negedge clk);
        total++; if (pulse_cnt !== 1) begin bad++; $display("[TB] FAIL last_bit_pulses: got %0d want 1", pulse_cnt); end
    endtask

    task automatic test_reset_mid_miso();
        drive_frame(10'h20F);
        end_frame();
        drive_frame(10'h300);
        @(negedge clk);
        total++; if (dut.state !== S_READ_DATA) begin bad++; $display("[TB] FAIL rst_setup_state: got %0d want %0d", dut.state, S_READ_DATA); end
        tx_data = 8'hFF; tx_valid = 1'b1;
        for (int i = 7; i >= 3; i--) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        total++; if (MISO !== 1'b1) begin bad++; $display("[TB] FAIL rst_bit3_miso: got %b want 1", MISO); end
        #2 rst = 1'b1;
        #1;
        total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_miso: got %b want 0", MISO); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_valid: got %b want 0", rx_valid); end
        total++; if (dut.rd_addr_flag !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_flag: got %b want 0", dut.rd_addr_flag); end
        total++; if (rx_data !== 10'h000) begin bad++; $display("[TB] FAIL rst_async_data: got %h want 000", rx_data); end
        SS_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_frame(10'h300);
        @(negedge clk);
        total++; if (dut.state !== S_READ_ADD) begin bad++; $display("[TB] FAIL noaddr_state: got %0d want %0d", dut.state, S_READ_ADD); end
        total++; if (rx_data !== 10'h300) begin bad++; $display("[TB] FAIL noaddr_data: got %h want 300", rx_data); end
        total++; if (dut.rd_addr_flag !== 1'b1) begin bad++; $display("[TB] FAIL noaddr_flag: got %b want 1", dut.rd_addr_flag); end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read_sequence();
        test_abort();
        test_ss_rise_on_last_bit();
        test_reset_mid_miso();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
